// File: rtl/inverter_pipe.sv
// Masked, enable-gated word inverter followed by a DEPTH-stage valid/ready
// pipeline with backpressure and a wrapping count of delivered words.
module inverter_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [WIDTH-1:0] INV_MASK = '1,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             invert_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_data,
  output logic [CNT_W-1:0] xfer_count
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] adv;
  logic             chain;

  // Ready ripples back from the output through a scalar accumulator rather
  // than reading adv[i+1] directly, so adv has no self-referencing bits.
  always_comb begin
    adv   = '0;
    chain = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      chain             = ~vld_q[DEPTH-1-i] | chain;
      adv[DEPTH-1-i]    = chain;
    end
  end

  assign in_ready    = adv[0];
  assign out_valid   = vld_q[DEPTH-1];
  assign output_data = data_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      vld_q      <= '0;
      xfer_count <= '0;
    end else begin
      if (adv[0]) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= input_data ^ (INV_MASK & {WIDTH{invert_en}});
        end
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          data_q[i] <= data_q[i-1];
          vld_q[i]  <= vld_q[i-1];
        end
      end
      if (out_valid & out_ready) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
    end
  end

endmodule
